hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the stall and flush event counters.
REQ-002 Parameter WDOG_LIMIT, default 255, SHALL set the consecutive data-memory-wait cycles that trigger timeout_err (8-bit watchdog).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Ports id_rs1, id_rs2, input, 5 each: source registers of the instruction in ID.
REQ-006 Ports id_use_rs1, id_use_rs2, input, 1 each: the ID instruction reads rs1/rs2.
REQ-007 Ports ex_rd (input, 5) and ex_mem_read (input, 1): destination and load flag of the instruction in EX.
REQ-008 Port ex_redirect, input, 1: branch taken or jump resolved in EX, so PC loads the target.
REQ-009 Port imem_ready, input, 1: the fetch word is valid this cycle.
REQ-010 Ports dmem_req and dmem_ready, input, 1 each: MEM-stage access pending, and that access completes this cycle.
REQ-011 Ports pc_en, if_id_en, id_ex_en, ex_mem_en, output, 1 each: load enables for the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-012 Ports if_id_flush, id_ex_flush, mem_wb_flush, output, 1 each: load a bubble (all-zero) into that pipeline register.
REQ-013 Port hz_state, output, 3: registered cause of the previous cycle.
REQ-014 Ports stall_cnt and flush_cnt, output, CNT_W each: saturating event counters.
REQ-015 Port timeout_err, output, 1: sticky data-memory watchdog error.

Function
REQ-016 Control outputs SHALL be combinational, with zero-cycle latency, from the current inputs, evaluated in priority order P1 to P5.
REQ-017 P1 MEM_WAIT (dmem_req and not dmem_ready): all four enables 0, mem_wb_flush 1, other flushes 0; ex_redirect and load-use are ignored and re-evaluated once the wait ends, because EX is frozen.
REQ-018 P2 REDIRECT (ex_redirect): pc_en 1, if_id_flush 1, id_ex_flush 1, ex_mem_en 1.
REQ-019 P3 LOAD_USE, detection: ex_mem_read, ex_rd nonzero, and ex_rd equal to an ID source whose use flag is set (rs1 or rs2).
REQ-020 P3 LOAD_USE, response: pc_en 0, if_id_en 0, id_ex_flush 1, ex_mem_en 1; exactly one bubble per load.
REQ-021 P4 FETCH_WAIT (not imem_ready): pc_en 0, if_id_flush 1, downstream enables 1.
REQ-022 P5 RUN: all enables 1, all flushes 0.
REQ-023 Encoding: a flush is asserted only together with the enable of the same register (a flush with its enable at 0 is illegal).
REQ-024 hz_state SHALL register the selected cause each cycle: RUN=0, LU_STALL=1, REDIRECT=2, MEM_WAIT=3, FETCH_WAIT=4.
REQ-025 stall_cnt SHALL increment by 1 in each LOAD_USE or MEM_WAIT cycle and saturate at all-ones, never wrapping.
REQ-026 flush_cnt SHALL increment by 1 in each REDIRECT cycle and saturate at all-ones.
REQ-027 The watchdog SHALL count consecutive MEM_WAIT cycles and clear on any non-MEM_WAIT cycle.
REQ-028 timeout_err SHALL be set on the edge where the watchdog reaches WDOG_LIMIT, and then stay set until reset.
REQ-029 Simultaneous redirect and load-use: the redirect wins, and the younger load-use victim is flushed, so it is never stalled.

Reset
REQ-030 While rst is low, all enables SHALL be 0 and all flushes 0.
REQ-031 While rst is low, hz_state SHALL be RUN, both counters 0, the watchdog 0 and timeout_err 0, taking effect immediately (asynchronously).
REQ-032 Deassertion SHALL be sampled on clk; the first active cycle follows normal priority.
REQ-033 Reset during MEM_WAIT SHALL abort the wait with no residual state.

Structure
REQ-034 Package hazard_pkg SHALL hold the hz_state encoding constants and the CNT_W default.
REQ-035 Sub-module sat_counter (width parameter, inc input, async active-low reset) SHALL be instantiated twice, for stall_cnt and flush_cnt.
REQ-036 No other sub-modules are permitted.

Verification
REQ-037 Load-use scenario:
- Stimulus: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle.
- Response: pc_en=0, if_id_en=0, id_ex_flush=1; next cycle hz_state=1, stall_cnt=1.
REQ-038 ex_rd=0 scenario:
- Stimulus: ex_mem_read=1, ex_rd=0, id_rs1=0, id_use_rs1=1.
- Response: all enables 1, no flush, stall_cnt unchanged.
REQ-039 Redirect with load-use scenario:
- Stimulus: ex_redirect=1 together with a load-use match.
- Response: pc_en=1, if_id_flush=1, id_ex_flush=1; flush_cnt+1, stall_cnt unchanged.
REQ-040 MEM_WAIT over redirect scenario:
- Stimulus: dmem_req=1, dmem_ready=0 for 3 cycles with ex_redirect=1, then dmem_ready=1.
- Response: 3 cycles of all enables 0 and mem_wb_flush=1, stall_cnt=3; the following cycle is REDIRECT.
- Watchdog sub-case, WDOG_LIMIT=4: hold dmem_ready=0 for 4 cycles; timeout_err=1 stays set after the wait ends, until rst is pulsed low.
REQ-041 Saturation and reset scenario:
- Stimulus: CNT_W=4, 20 REDIRECT cycles.
- Response: flush_cnt=15; rst low mid-cycle forces flush_cnt=0 and all enables 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Hazard-control shared definitions: cause encoding, counter width default, load-use match.
// Pure declarations; no latency, no flow control.
package hazard_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        HZ_RUN        = 3'd0,
        HZ_LU_STALL   = 3'd1,
        HZ_REDIRECT   = 3'd2,
        HZ_MEM_WAIT   = 3'd3,
        HZ_FETCH_WAIT = 3'd4
    } hz_cause_t;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       use_rs1,
        input logic [4:0] rs2,
        input logic       use_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; one-cycle update latency.
// No flow control: inc is sampled every cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush decode (zero latency) plus registered cause,
// event counters and a sticky data-memory watchdog; pipeline enables are the backpressure it applies.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WDOG_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [2:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             timeout_err
);

    localparam logic [7:0] WDOG_LIM8 = 8'(WDOG_LIMIT);

    hz_cause_t  cause;
    hz_cause_t  cause_q;
    logic       mem_wait;
    logic       lu_hit;
    logic [7:0] wdog;

    assign mem_wait = dmem_req && !dmem_ready;
    assign lu_hit   = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2);

    // A frozen EX hides redirect and load-use; they are re-evaluated once the wait ends.
    always_comb begin
        cause = HZ_RUN;
        if (mem_wait)         cause = HZ_MEM_WAIT;
        else if (ex_redirect) cause = HZ_REDIRECT;
        else if (lu_hit)      cause = HZ_LU_STALL;
        else if (!imem_ready) cause = HZ_FETCH_WAIT;
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            case (cause)
                HZ_MEM_WAIT: begin
                    mem_wb_flush = 1'b1;
                end
                HZ_REDIRECT: begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                HZ_LU_STALL: begin
                    id_ex_en    = 1'b1;
                    ex_mem_en   = 1'b1;
                    id_ex_flush = 1'b1;
                end
                HZ_FETCH_WAIT: begin
                    {if_id_en, id_ex_en, ex_mem_en} = 3'b111;
                    if_id_flush = 1'b1;
                end
                default: begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cause_q     <= HZ_RUN;
            wdog        <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            cause_q <= cause;
            if (cause == HZ_MEM_WAIT) begin
                if (wdog != 8'hFF) begin
                    wdog <= wdog + 8'd1;
                    if ((wdog + 8'd1) == WDOG_LIM8) timeout_err <= 1'b1;
                end
            end else begin
                wdog <= 8'd0;
            end
        end
    end

    assign hz_state = cause_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc ((cause == HZ_LU_STALL) || (cause == HZ_MEM_WAIT)),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cause == HZ_REDIRECT),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int CW   = 4;
    localparam int WLIM = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_redirect = 0;
    logic          imem_ready = 1, dmem_req = 0, dmem_ready = 1;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic          if_id_flush, id_ex_flush, mem_wb_flush;
    logic [2:0]    hz_state;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    int m_state = 0, m_stall = 0, m_flush = 0, m_wdog = 0, m_err = 0;

    hazard_ctrl #(.CNT_W(CW), .WDOG_LIMIT(WLIM)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // cause: 0 run, 1 load-use, 2 redirect, 3 mem wait, 4 fetch wait
    function automatic int exp_cause();
        bit lu;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (dmem_req && !dmem_ready) return 3;
        if (ex_redirect)             return 2;
        if (lu)                      return 1;
        if (!imem_ready)             return 4;
        return 0;
    endfunction

    // {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, mem_wb_flush}
    function automatic int exp_ctl(input int c);
        case (c)
            1:       return 'b0011_010;
            2:       return 'b1111_110;
            3:       return 'b0000_001;
            4:       return 'b0111_100;
            default: return 'b1111_000;
        endcase
    endfunction

    function automatic int act_ctl();
        return int'({pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush});
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 0; m_stall = 0; m_flush = 0; m_wdog = 0; m_err = 0;
        end else begin
            m_state = exp_cause();
            if ((m_state == 1 || m_state == 3) && m_stall < CMAX) m_stall++;
            if (m_state == 2 && m_flush < CMAX) m_flush++;
            if (m_state == 3) begin
                m_wdog++;
                if (m_wdog == WLIM) m_err = 1;
            end else begin
                m_wdog = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("ctl", act_ctl(), rst ? exp_ctl(exp_cause()) : 0);
        chk("hz_state", int'(hz_state), m_state);
        chk("stall_cnt", int'(stall_cnt), m_stall);
        chk("flush_cnt", int'(flush_cnt), m_flush);
        chk("timeout_err", int'(timeout_err), m_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_mem_read = 0; ex_redirect = 0;
        imem_ready = 1; dmem_req = 0; dmem_ready = 1;
    endtask

    task automatic pulse_rst();
        rst = 0;
        #1;
        rst = 1;
    endtask

    initial begin
        idle_in();
        #2;
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_ctl", act_ctl(), 0);
        chk("rst_hz_state", int'(hz_state), 0);
        chk("rst_stall", int'(stall_cnt), 0);
        tick();
        tick();
        rst = 1;

        // load-use on rs2
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        #1;
        chk("lu_pc_en", int'(pc_en), 0);
        chk("lu_if_id_en", int'(if_id_en), 0);
        chk("lu_id_ex_flush", int'(id_ex_flush), 1);
        tick();
        chk("lu_hz_state", int'(hz_state), 1);
        chk("lu_stall", int'(stall_cnt), 1);

        // load to x0 is not a hazard
        idle_in();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        #1;
        chk("x0_ctl", act_ctl(), 'b1111_000);
        tick();
        chk("x0_stall", int'(stall_cnt), 1);

        // redirect beats load-use
        idle_in();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; ex_redirect = 1;
        #1;
        chk("rdlu_pc_en", int'(pc_en), 1);
        chk("rdlu_if_id_flush", int'(if_id_flush), 1);
        chk("rdlu_id_ex_flush", int'(id_ex_flush), 1);
        tick();
        chk("rdlu_flush", int'(flush_cnt), 1);
        chk("rdlu_stall", int'(stall_cnt), 1);

        // mem wait masks redirect for 3 cycles
        idle_in();
        pulse_rst();
        chk("rst2_stall", int'(stall_cnt), 0);
        dmem_req = 1; dmem_ready = 0; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_ctl", act_ctl(), 'b0000_001);
            tick();
        end
        chk("mw_stall", int'(stall_cnt), 3);
        chk("mw_hz_state", int'(hz_state), 3);
        chk("mw_err", int'(timeout_err), 0);
        dmem_ready = 1;
        #1;
        chk("mw_after_ctl", act_ctl(), 'b1111_110);
        tick();
        chk("mw_after_hz", int'(hz_state), 2);
        chk("mw_after_flush", int'(flush_cnt), 1);

        // watchdog
        idle_in();
        pulse_rst();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("wd_err_early", int'(timeout_err), 0);
        tick();
        chk("wd_err_set", int'(timeout_err), 1);
        dmem_ready = 1;
        tick();
        tick();
        chk("wd_err_sticky", int'(timeout_err), 1);
        rst = 0;
        #1;
        chk("wd_err_cleared", int'(timeout_err), 0);
        rst = 1;

        // flush counter saturation, then asynchronous reset
        idle_in();
        ex_redirect = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_flush", int'(flush_cnt), 15);
        rst = 0;
        #1;
        chk("sat_rst_flush", int'(flush_cnt), 0);
        chk("sat_rst_pc_en", int'(pc_en), 0);
        chk("sat_rst_ctl", act_ctl(), 0);
        tick();
        rst = 1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) != 0);
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = $urandom_range(0, 1) == 1;
            id_use_rs2  = $urandom_range(0, 1) == 1;
            ex_mem_read = $urandom_range(0, 2) == 0;
            ex_redirect = $urandom_range(0, 6) == 0;
            imem_ready  = $urandom_range(0, 4) != 0;
            dmem_req    = $urandom_range(0, 2) == 0;
            dmem_ready  = $urandom_range(0, 2) == 0;
            tick();
        end

        idle_in();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
